midi_rx_parser: RTL

MIDI_RX_PARSER -- requirements
Module: midi_rx_parser

---
 rtl/midi_rx_parser.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/midi_rx_parser.sv
// MIDI serial receiver plus channel-message assembler.
// The UART recovers 8N1 bytes from the 31250-baud line. The parser then
// applies running status and drops real-time and system bytes. Each
// completed channel message is presented through a valid/ready handshake.
module midi_rx_parser #(
   parameter int CLKS_PER_BIT = 320
) (
   input  logic       SYSCLK,
   input  logic       SYSRESET,
   input  logic       MIDI_RX,
   output logic [7:0] RX_BYTE,
   output logic       RXRDY,
   output logic       FRAME_ERR,
   output logic       MSG_VALID,
   input  logic       MSG_READY,
   output logic [7:0] MSG_STATUS,
   output logic [6:0] MSG_DATA1,
   output logic [6:0] MSG_DATA2,
   output logic       OVERRUN
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_t;

   // synchronizer and edge history
   logic            rx_meta_q, rx_sync_q, rx_prev_q;
   // UART state
   uart_st_t        st_q, st_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rx_byte_q, rx_byte_d;
   logic            rxrdy_q, rxrdy_d;
   logic            ferr_q, ferr_d;
   // parser state (rs_q == 0 means no running status)
   logic [7:0]      rs_q, rs_d;
   logic            dcnt_q, dcnt_d;
   logic [6:0]      d1h_q, d1h_d;
   // presented message
   logic            vld_q, vld_d;
   logic [7:0]      stat_q, stat_d;
   logic [6:0]      d1_q, d1_d, d2_q, d2_d;
   logic            ovr_q, ovr_d;
   // completion of a message this cycle
   logic            done;
   logic [6:0]      c_d1, c_d2;

   // UART next state: half-bit delay to the start-bit centre, then whole-bit steps
   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      rx_byte_d = rx_byte_q;
      rxrdy_d   = 1'b0;
      ferr_d    = 1'b0;
      unique case (st_q)
         IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               st_d  = START;
               cnt_d = HALF_LD;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               if (rx_sync_q) begin
                  st_d = IDLE;        // too short to be a start bit
               end else begin
                  st_d  = DATA;
                  cnt_d = FULL_LD;
                  bit_d = 3'd0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_sync_q, shift_q[7:1]};
               cnt_d   = FULL_LD;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) st_d = STOP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == '0) begin
               st_d = IDLE;
               if (rx_sync_q) begin
                  rx_byte_d = shift_q;
                  rxrdy_d   = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   // parser: running status, data collection and the handshake on the output message
   always_comb begin
      rs_d   = rs_q;
      dcnt_d = dcnt_q;
      d1h_d  = d1h_q;
      done   = 1'b0;
      c_d1   = '0;
      c_d2   = '0;
      if (rxrdy_q) begin
         if (rx_byte_q[7:3] == 5'b11111) begin
            // real-time byte: transparent to the parser
         end else if (rx_byte_q[7:4] == 4'hF) begin
            rs_d   = '0;
            dcnt_d = 1'b0;
         end else if (rx_byte_q[7]) begin
            rs_d   = rx_byte_q;
            dcnt_d = 1'b0;
         end else if (rs_q != '0) begin
            if (!dcnt_q) begin
               if (rs_q[7:5] == 3'b110) begin
                  done = 1'b1;          // program change / channel pressure
                  c_d1 = rx_byte_q[6:0];
               end else begin
                  d1h_d  = rx_byte_q[6:0];
                  dcnt_d = 1'b1;
               end
            end else begin
               done   = 1'b1;
               c_d1   = d1h_q;
               c_d2   = rx_byte_q[6:0];
               dcnt_d = 1'b0;
            end
         end
      end

      vld_d  = vld_q & ~MSG_READY;
      stat_d = stat_q;
      d1_d   = d1_q;
      d2_d   = d2_q;
      ovr_d  = 1'b0;
      if (done) begin
         if (!vld_q || MSG_READY) begin
            vld_d  = 1'b1;
            stat_d = rs_q;
            d1_d   = c_d1;
            d2_d   = c_d2;
         end else begin
            ovr_d = 1'b1;          // consumer still holds the previous message
         end
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge SYSCLK) begin
      if (SYSRESET) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         st_q      <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_byte_q <= '0;
         rxrdy_q   <= 1'b0;
         ferr_q    <= 1'b0;
         rs_q      <= '0;
         dcnt_q    <= 1'b0;
         d1h_q     <= '0;
         vld_q     <= 1'b0;
         stat_q    <= '0;
         d1_q      <= '0;
         d2_q      <= '0;
         ovr_q     <= 1'b0;
      end else begin
         rx_meta_q <= MIDI_RX;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_byte_q <= rx_byte_d;
         rxrdy_q   <= rxrdy_d;
         ferr_q    <= ferr_d;
         rs_q      <= rs_d;
         dcnt_q    <= dcnt_d;
         d1h_q     <= d1h_d;
         vld_q     <= vld_d;
         stat_q    <= stat_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
         ovr_q     <= ovr_d;
      end
   end

   assign RX_BYTE    = rx_byte_q;
   assign RXRDY      = rxrdy_q;
   assign FRAME_ERR  = ferr_q;
   assign MSG_VALID  = vld_q;
   assign MSG_STATUS = stat_q;
   assign MSG_DATA1  = d1_q;
   assign MSG_DATA2  = d2_q;
   assign OVERRUN    = ovr_q;

endmodule
